// File: rtl/sm3_pkg.sv
// Shared SM3 compression types, constants and round helper functions.
package sm3_pkg;

    // Working state packed so that [7] is A and [0] is H, matching the digest layout.
    typedef logic [7:0][31:0] sm3_st_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FEED,
        ST_HOLD
    } sm3_state_e;

    localparam sm3_st_t     SM3_IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [31:0] T_LO   = 32'h79cc4519;
    localparam logic [31:0] T_HI   = 32'h7a879d8a;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
    endfunction

    function automatic logic [31:0] ff(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic lt16);
        return lt16 ? (x ^ y ^ z) : ((x & y) | (x & z) | (y & z));
    endfunction

    function automatic logic [31:0] gg(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z, input logic lt16);
        return lt16 ? (x ^ y ^ z) : ((x & y) | (~x & z));
    endfunction

endpackage

// File: rtl/sm3_cmprss_rnd.sv
// One combinational SM3 compression round; tj_i arrives already rotated by j mod 32.
module sm3_cmprss_rnd
    import sm3_pkg::*;
(
    input  sm3_st_t     st_i,
    input  logic [31:0] wj_i,
    input  logic [31:0] wjj_i,
    input  logic [31:0] tj_i,
    input  logic        lt16_i,
    output sm3_st_t     st_o
);

    logic [31:0] a12, ss1, ss2, tt1, tt2;

    always_comb begin
        a12  = rotl(st_i[7], 5'd12);
        ss1  = rotl(a12 + st_i[3] + tj_i, 5'd7);
        ss2  = ss1 ^ a12;
        tt1  = ff(st_i[7], st_i[6], st_i[5], lt16_i) + st_i[4] + ss2 + wjj_i;
        tt2  = gg(st_i[3], st_i[2], st_i[1], lt16_i) + st_i[0] + ss1 + wj_i;
        st_o = {tt1, st_i[7], rotl(st_i[6], 5'd9), st_i[5],
                p0(tt2), st_i[3], rotl(st_i[2], 5'd19), st_i[1]};
    end

endmodule

// File: rtl/sm3_cmprss_engine.sv
// SM3 compression engine: RND_PER_CYC rounds per beat, multi-block chaining, valid/ready both sides.
// Optional context restore (iv_i/iv_ld_i) is enabled by defining SM3_CMPRSS_IV_LOAD_EN.
module sm3_cmprss_engine
    import sm3_pkg::*;
#(
    parameter int RND_PER_CYC = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [32*RND_PER_CYC-1:0]  in_wj_i,
    input  logic [32*RND_PER_CYC-1:0]  in_wjj_i,
    input  logic                       in_lst_i,
    input  logic                       in_vld_i,
    output logic                       in_rdy_o,
    output logic [255:0]               out_res_o,
    output logic                       out_vld_o,
    input  logic                       out_rdy_i
`ifdef SM3_CMPRSS_IV_LOAD_EN
    ,
    input  logic [255:0]               iv_i,
    input  logic                       iv_ld_i
`endif
);

    localparam int BEATS = 64 / RND_PER_CYC;
    localparam int CW    = $clog2(BEATS);

    sm3_state_e    state;
    logic [CW-1:0] cnt;
    logic          lst_q;
    logic          rdy_q;
    sm3_st_t       v, st, st_nxt;
    logic          acc, last_beat, iv_ld;
    sm3_st_t       iv_val;

`ifdef SM3_CMPRSS_IV_LOAD_EN
    assign iv_ld  = (state == ST_IDLE) && iv_ld_i;
    assign iv_val = iv_i;
`else
    assign iv_ld  = 1'b0;
    assign iv_val = SM3_IV;
`endif

    // A restore cycle refuses the beat so that load and round update never collide.
    assign in_rdy_o  = rdy_q && !rst && !iv_ld;
    assign acc       = in_vld_i && in_rdy_o;
    assign last_beat = (cnt == CW'(BEATS - 1));

    for (genvar k = 0; k < RND_PER_CYC; k++) begin : g_rnd
        sm3_st_t     st_in, st_out;
        logic [5:0]  j;
        logic        lt16;
        logic [31:0] tj;

        if (k == 0) begin : g_head
            assign st_in = st;
        end else begin : g_link
            assign st_in = g_rnd[k-1].st_out;
        end

        assign j    = 6'(cnt * RND_PER_CYC + k);
        assign lt16 = (j < 6'd16);
        assign tj   = rotl(lt16 ? T_LO : T_HI, j[4:0]);

        sm3_cmprss_rnd u_rnd (
            .st_i   (st_in),
            .wj_i   (in_wj_i[32*(RND_PER_CYC-k)-1 -: 32]),
            .wjj_i  (in_wjj_i[32*(RND_PER_CYC-k)-1 -: 32]),
            .tj_i   (tj),
            .lt16_i (lt16),
            .st_o   (st_out)
        );
    end

    assign st_nxt = g_rnd[RND_PER_CYC-1].st_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            v         <= SM3_IV;
            st        <= SM3_IV;
            cnt       <= '0;
            lst_q     <= 1'b0;
            rdy_q     <= 1'b1;
            out_vld_o <= 1'b0;
            out_res_o <= SM3_IV;
        end else begin
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (iv_ld) begin
                        v  <= iv_val;
                        st <= iv_val;
                    end else if (acc) begin
                        st <= st_nxt;
                        if (last_beat) begin
                            cnt   <= '0;
                            lst_q <= in_lst_i;
                            rdy_q <= 1'b0;
                            state <= ST_FEED;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= ST_RUN;
                        end
                    end
                end
                ST_FEED: begin
                    v  <= v ^ st;
                    st <= v ^ st;
                    if (lst_q) begin
                        out_res_o <= v ^ st;
                        out_vld_o <= 1'b1;
                        state     <= ST_HOLD;
                    end else begin
                        rdy_q <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (out_rdy_i) begin
                        v         <= SM3_IV;
                        st        <= SM3_IV;
                        lst_q     <= 1'b0;
                        out_vld_o <= 1'b0;
                        rdy_q     <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm3_cmprss_engine.sv
// Directed bench: three engines (1/2/4 rounds per beat) fed by a bench-side SM3 message expander.
module tb_sm3_cmprss_engine;

    localparam logic [255:0] IV   = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [255:0] ABC  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] ABCD = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] wj_bus, wjj_bus;
    logic [2:0]   vld, lst, ordy, irdy, ovld;
    logic [255:0] res [3];
`ifdef SM3_CMPRSS_IV_LOAD_EN
    logic [255:0] iv;
    logic         iv_ld;
`endif

    logic [31:0] blk [16];
    logic [31:0] w   [68];
    logic [31:0] wp  [64];
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sm3_cmprss_engine #(.RND_PER_CYC(1)) u_r1 (
`ifdef SM3_CMPRSS_IV_LOAD_EN
        .iv_i(iv), .iv_ld_i(iv_ld),
`endif
        .clk(clk), .rst(rst), .in_wj_i(wj_bus[31:0]), .in_wjj_i(wjj_bus[31:0]),
        .in_lst_i(lst[0]), .in_vld_i(vld[0]), .in_rdy_o(irdy[0]),
        .out_res_o(res[0]), .out_vld_o(ovld[0]), .out_rdy_i(ordy[0]));

    sm3_cmprss_engine #(.RND_PER_CYC(2)) u_r2 (
`ifdef SM3_CMPRSS_IV_LOAD_EN
        .iv_i(iv), .iv_ld_i(iv_ld),
`endif
        .clk(clk), .rst(rst), .in_wj_i(wj_bus[63:0]), .in_wjj_i(wjj_bus[63:0]),
        .in_lst_i(lst[1]), .in_vld_i(vld[1]), .in_rdy_o(irdy[1]),
        .out_res_o(res[1]), .out_vld_o(ovld[1]), .out_rdy_i(ordy[1]));

    sm3_cmprss_engine #(.RND_PER_CYC(4)) u_r4 (
`ifdef SM3_CMPRSS_IV_LOAD_EN
        .iv_i(iv), .iv_ld_i(iv_ld),
`endif
        .clk(clk), .rst(rst), .in_wj_i(wj_bus), .in_wjj_i(wjj_bus),
        .in_lst_i(lst[2]), .in_vld_i(vld[2]), .in_rdy_o(irdy[2]),
        .out_res_o(res[2]), .out_vld_o(ovld[2]), .out_rdy_i(ordy[2]));

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    task automatic check_w(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // 0: "abc" padded, 1: first block of "abcd"x16, 2: its padding block
    task automatic set_blk(input int id);
        logic [31:0] x;
        for (int i = 0; i < 16; i++) blk[i] = (id == 1) ? 32'h61626364 : 32'h0;
        if (id == 0) begin blk[0] = 32'h61626380; blk[15] = 32'h00000018; end
        if (id == 2) begin blk[0] = 32'h80000000; blk[15] = 32'h00000200; end
        for (int i = 0; i < 16; i++) w[i] = blk[i];
        for (int i = 16; i < 68; i++) begin
            x    = w[i-16] ^ w[i-9] ^ rl(w[i-3], 15);
            w[i] = (x ^ rl(x, 15) ^ rl(x, 23)) ^ rl(w[i-13], 7) ^ w[i-6];
        end
        for (int i = 0; i < 64; i++) wp[i] = w[i] ^ w[i+4];
    endtask

    // Feeds beats [b0,b1) of the current block; called and returns just after a rising edge.
    task automatic feed(input int s, input int r, input bit lst_v, input bit gaps,
                        input bit noise, input int b0, input int b1);
        int beats = 64 / r;
        for (int b = b0; b < b1; b++) begin
            int t = 0;
            for (int k = 0; k < r; k++) begin
                wj_bus[32*(r-1-k) +: 32]  = w[b*r+k];
                wjj_bus[32*(r-1-k) +: 32] = wp[b*r+k];
            end
            lst[s] = (b == beats - 1) ? lst_v : noise;
            forever begin
                vld[s] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                @(negedge clk);
                if (vld[s] && irdy[s]) begin
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
                t++;
                if (t > 40) begin
                    check_b("beat_timeout_rdy", irdy[s], 1'b1);
                    vld[s] = 1'b0;
                    lst[s] = 1'b0;
                    return;
                end
            end
        end
        vld[s] = 1'b0;
        lst[s] = 1'b0;
    endtask

    task automatic blk_gap(input int s);
        @(negedge clk);
        check_b("feed_rdy_low", irdy[s], 1'b0);
        check_b("feed_no_vld", ovld[s], 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_b("run_rdy_high", irdy[s], 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic digest(input int s, input logic [255:0] exp, input int hold);
        @(negedge clk);
        check_b("lat1_vld_low", ovld[s], 1'b0);
        check_b("lat1_rdy_low", irdy[s], 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_b("lat2_vld_high", ovld[s], 1'b1);
        check_w("digest", res[s], exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_w("hold_res_stable", res[s], exp);
            check_b("hold_vld", ovld[s], 1'b1);
            check_b("hold_rdy_low", irdy[s], 1'b0);
        end
        @(posedge clk); #1;
        ordy[s] = 1'b1;
        @(posedge clk); #1;
        ordy[s] = 1'b0;
        @(negedge clk);
        check_b("post_vld_low", ovld[s], 1'b0);
        check_b("post_rdy_high", irdy[s], 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic run_abcd(input int s, input int r, input bit gaps, input int hold);
        set_blk(1);
        feed(s, r, 1'b0, gaps, 1'b0, 0, 64 / r);
        blk_gap(s);
        set_blk(2);
        feed(s, r, 1'b1, gaps, 1'b0, 0, 64 / r);
        digest(s, ABCD, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; vld = '0; lst = '0; ordy = '0; wj_bus = '0; wjj_bus = '0;
`ifdef SM3_CMPRSS_IV_LOAD_EN
        iv = '0; iv_ld = 1'b0;
`endif
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check_b("rst_rdy_low", irdy[s], 1'b0);
            check_b("rst_vld_low", ovld[s], 1'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check_w("rst_res_iv", res[s], IV);
            check_b("idle_vld_low", ovld[s], 1'b0);
            check_b("idle_rdy_high", irdy[s], 1'b1);
        end
        @(posedge clk); #1;

        // "abc", one round per beat, valid held high
        set_blk(0);
        feed(0, 1, 1'b1, 1'b0, 1'b0, 0, 64);
        digest(0, ABC, 2);

        // two-block message at 2 and 4 rounds per beat
        run_abcd(1, 2, 1'b0, 0);
        run_abcd(2, 4, 1'b0, 0);

        // random input gaps and a reader that stalls 10 cycles
        run_abcd(2, 4, 1'b1, 10);
        set_blk(0);
        feed(0, 1, 1'b1, 1'b1, 1'b0, 0, 64);
        digest(0, ABC, 10);

        // in_lst_i high on every non-final beat of a non-last block must not end the message
        set_blk(1);
        feed(0, 1, 1'b0, 1'b0, 1'b1, 0, 64);
        blk_gap(0);
        set_blk(2);
        feed(0, 1, 1'b1, 1'b0, 1'b1, 0, 64);
        digest(0, ABCD, 0);

        // back-to-back "abc" messages
        set_blk(0);
        feed(1, 2, 1'b1, 1'b0, 1'b1, 0, 32);
        digest(1, ABC, 0);
        feed(1, 2, 1'b1, 1'b0, 1'b0, 0, 32);
        digest(1, ABC, 0);

        // reset 30 beats into a block, then a clean "abc"
        set_blk(0);
        feed(0, 1, 1'b1, 1'b0, 1'b0, 0, 30);
        rst = 1'b1;
        @(negedge clk);
        check_b("midrst_rdy_low", irdy[0], 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_b("midrst_no_vld", ovld[0], 1'b0);
            check_w("midrst_res_iv", res[0], IV);
            check_b("midrst_rdy_high", irdy[0], 1'b1);
            @(posedge clk); #1;
        end
        feed(0, 1, 1'b1, 1'b0, 1'b0, 0, 64);
        digest(0, ABC, 1);

`ifdef SM3_CMPRSS_IV_LOAD_EN
        // restore: a junk load overwritten by a later load of IV, then a junk load mid-block ignored
        iv = {8{32'hdeadbeef}};
        iv_ld = 1'b1;
        @(negedge clk);
        check_b("ivld_blocks_rdy", irdy[0], 1'b0);
        @(posedge clk); #1;
        iv = IV;
        @(posedge clk); #1;
        iv_ld = 1'b0;
        set_blk(0);
        feed(0, 1, 1'b1, 1'b0, 1'b0, 0, 20);
        iv = {8{32'h01234567}};
        iv_ld = 1'b1;
        feed(0, 1, 1'b1, 1'b0, 1'b0, 20, 64);
        iv_ld = 1'b0;
        digest(0, ABC, 0);
        feed(0, 1, 1'b1, 1'b0, 1'b0, 0, 64);
        digest(0, ABC, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
